// File: rtl/control_dispatch_pkg.sv
// +----------------------------------------------------------------------+
// | control_pkg : shared command-word constants and typedef               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package control_pkg;
  localparam int CTRL_WORD_W   = 40;
  localparam int CTRL_ADDR_W   = 8;
  localparam int CTRL_DATA_W   = 32;
  localparam int CTRL_ADDR_MSB = 39;
  localparam int CTRL_ADDR_LSB = 32;

  typedef struct packed {
    logic [CTRL_ADDR_W-1:0] addr;
    logic [CTRL_DATA_W-1:0] data;
  } ctrl_cmd_t;
endpackage

`default_nettype wire

// File: rtl/control_dispatch_if.sv
// +----------------------------------------------------------------------+
// | control_dispatch_if : local register-bus write handshake             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface control_dispatch_if #(
  parameter int AW = 8,
  parameter int DW = 32
) ();
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_data;
  logic          lb_valid;
  logic          lb_ready;

  modport master (output lb_addr, output lb_data, output lb_valid, input  lb_ready);
  modport slave  (input  lb_addr, input  lb_data, input  lb_valid, output lb_ready);
endinterface

`default_nettype wire

// File: rtl/control_dispatch_fifo.sv
// +----------------------------------------------------------------------+
// | ctrl_fifo : sync FIFO with registered first-word-fall-through output |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ctrl_fifo #(
  parameter int WIDTH = 40,
  parameter int AW    = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             wr_en_i,
  input  wire logic [WIDTH-1:0] din_i,
  input  wire logic             rd_ready_i,
  output      logic [WIDTH-1:0] dout_o,
  output      logic             valid_o,
  output      logic             full_o,
  output      logic             empty_o,
  output      logic [AW:0]      level_o
);
  localparam logic [AW:0] C_CAPACITY = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;

  logic             pop, mem_empty, wr, load;
  logic [AW:0]      level;

  assign pop       = valid_q & rd_ready_i;
  assign mem_empty = (wptr_q == rptr_q);
  // Occupancy includes the output register so capacity is exactly 2**AW.
  assign level     = (wptr_q - rptr_q) + {{AW{1'b0}}, valid_q};
  assign full_o    = (level == C_CAPACITY);
  assign wr        = wr_en_i & (~full_o | pop);
  assign load      = ~mem_empty & (~valid_q | rd_ready_i);

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (load) begin
        dout_q  <= mem_q[rptr_q[AW-1:0]];
        valid_q <= 1'b1;
        rptr_q  <= rptr_q + 1'b1;
      end else if (rd_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign empty_o = ~valid_q;
  assign level_o = level;
endmodule

`default_nettype wire

// File: rtl/control_dispatch.sv
// +----------------------------------------------------------------------+
// | control_dispatch : queues JTAG control words onto the register bus  |
// | Optional CONTROL_DISPATCH_COUNT_EN adds cmd_count/drop_count. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module control_dispatch
  import control_pkg::*;
#(
  parameter int AW      = CTRL_ADDR_W,
  parameter int DW      = CTRL_DATA_W,
  parameter int FIFO_AW = 2
) (
  input  wire logic                   usbclk,
  input  wire logic                   reset,
  input  wire logic [CTRL_WORD_W-1:0] control_bus,
  input  wire logic                   control_strobe,
  control_dispatch_if.master          lb,
  output      logic                   overflow,
  input  wire logic                   overflow_clr,
`ifdef CONTROL_DISPATCH_COUNT_EN
  output      logic [15:0]            cmd_count,
  output      logic [7:0]             drop_count,
`endif
  output      logic [FIFO_AW:0]       fifo_level
);
  ctrl_cmd_t head;
  logic      head_valid, fifo_full, fifo_empty;
  logic      xfer, drop, accept;
  logic      overflow_q;

  ctrl_fifo #(
    .WIDTH (CTRL_WORD_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk        (usbclk),
    .rst        (reset),
    .wr_en_i    (control_strobe),
    .din_i      (control_bus),
    .rd_ready_i (lb.lb_ready),
    .dout_o     (head),
    .valid_o    (head_valid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign lb.lb_addr  = head.addr;
  assign lb.lb_data  = head.data;
  assign lb.lb_valid = head_valid;

  // A transfer in the same cycle frees a slot, so a full FIFO still accepts.
  assign xfer   = head_valid & lb.lb_ready;
  assign drop   = control_strobe & fifo_full & ~xfer;
  assign accept = control_strobe & ~drop;

  always_ff @(posedge usbclk or posedge reset) begin
    if (reset)             overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (overflow_clr) overflow_q <= 1'b0;
  end
  assign overflow = overflow_q;

`ifdef CONTROL_DISPATCH_COUNT_EN
  logic [15:0] cmd_count_q;
  logic [7:0]  drop_count_q;

  always_ff @(posedge usbclk or posedge reset) begin
    if (reset) begin
      cmd_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (accept) cmd_count_q <= cmd_count_q + 16'd1;
      if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
    end
  end
  assign cmd_count  = cmd_count_q;
  assign drop_count = drop_count_q;
`else
  logic unused_ok;
  assign unused_ok = accept | fifo_empty;
`endif

`ifdef CONTROL_DISPATCH_COUNT_EN
  logic unused_empty;
  assign unused_empty = fifo_empty;
`endif
endmodule

`default_nettype wire
